// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, the canonical NOP and the
// fetched-instruction entry type used between fetch and decode.
package riscv_pkg;

  localparam int unsigned ILEN_DEFAULT = 32;
  localparam int unsigned XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue_ptr.sv
// Wrapping queue pointer with increment enable and synchronous clear.
// Wrap-around comes for free because the queue depth is a power of two.
module instr_queue_ptr #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (incr) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/instr_queue.sv
// Instruction prefetch FIFO between instruction memory and decode, tagging each
// instruction with its PC; flush discards every buffered entry on a redirect.
module instr_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     ILEN        = ILEN_DEFAULT,
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter int unsigned     DEPTH       = 4,
  parameter logic [ILEN-1:0] RESET_INSTR = NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Handshake readiness depends on registered occupancy only, never on the peer's valid/ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  instr_queue_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .incr  (pop),
    .ptr   (rd_ptr)
  );

  instr_queue_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .incr  (push),
    .ptr   (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = '{instr: in_instr, pc: in_pc};
    end
  end

  // Storage is deliberately left out of reset and flush; the pointers alone define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_instr = out_valid ? mem_q[rd_ptr].instr : RESET_INSTR;
  assign out_pc    = out_valid ? mem_q[rd_ptr].pc    : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH = 4): a table of per-cycle vectors
// whose expectations describe the state seen before each clock edge, plus hand sequences.
module tb_instr_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        flush;
    logic        inValid;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        outReady;
    logic        expInReady;
    logic        expOutValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic [2:0]  expCount;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int vecCount = 0;
  int missCount = 0;
  vec_t vecs[$];

  instr_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic fl, input logic iv, input logic [31:0] ii,
                                 input logic [31:0] ip, input logic ordy, input logic eir,
                                 input logic eov, input logic [31:0] ei, input logic [31:0] ep,
                                 input logic [2:0] ec);
    vec_t v;
    v.flush = fl; v.inValid = iv; v.inInstr = ii; v.inPc = ip; v.outReady = ordy;
    v.expInReady = eir; v.expOutValid = eov; v.expInstr = ei; v.expPc = ep; v.expCount = ec;
    return v;
  endfunction

  task automatic applyStimulus(input logic fl, input logic iv, input logic [31:0] ii,
                               input logic [31:0] ip, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_instr  = ii;
    in_pc     = ip;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic eir, input logic eov,
                             input logic [31:0] ei, input logic [31:0] ep, input logic [2:0] ec);
    vecCount++;
    if (in_ready !== eir) begin
      missCount++;
      $display("[TB] FAIL %s in_ready: got %b want %b", name, in_ready, eir);
    end
    if (out_valid !== eov) begin
      missCount++;
      $display("[TB] FAIL %s out_valid: got %b want %b", name, out_valid, eov);
    end
    if (out_instr !== ei) begin
      missCount++;
      $display("[TB] FAIL %s out_instr: got %h want %h", name, out_instr, ei);
    end
    if (out_pc !== ep) begin
      missCount++;
      $display("[TB] FAIL %s out_pc: got %h want %h", name, out_pc, ep);
    end
    if (count !== ec) begin
      missCount++;
      $display("[TB] FAIL %s count: got %0d want %0d", name, count, ec);
    end
  endtask

  initial begin
    // Idle and fill to full with out_ready low; the 5th offer must be refused.
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 0, NOP,          32'h0,  0));
    vecs.push_back(mkVec(0, 1, 32'h11111111, 32'h0,  0, 1, 0, NOP,          32'h0,  0));
    vecs.push_back(mkVec(0, 1, 32'h22222222, 32'h4,  0, 1, 1, 32'h11111111, 32'h0,  1));
    vecs.push_back(mkVec(0, 1, 32'h33333333, 32'h8,  0, 1, 1, 32'h11111111, 32'h0,  2));
    vecs.push_back(mkVec(0, 1, 32'h44444444, 32'hC,  0, 1, 1, 32'h11111111, 32'h0,  3));
    vecs.push_back(mkVec(0, 1, 32'h55555555, 32'h10, 0, 0, 1, 32'h11111111, 32'h0,  4));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 0, 1, 32'h11111111, 32'h0,  4));
    // Drain in order.
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 0, 1, 32'h11111111, 32'h0,  4));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 1, 1, 32'h22222222, 32'h4,  3));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 1, 1, 32'h33333333, 32'h8,  2));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 1, 1, 32'h44444444, 32'hC,  1));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 0, NOP,          32'h0,  0));
    // Streaming at count 2 with both pointers wrapping.
    vecs.push_back(mkVec(0, 1, 32'hA0A0A0A0, 32'h20, 0, 1, 0, NOP,          32'h0,  0));
    vecs.push_back(mkVec(0, 1, 32'hA1A1A1A1, 32'h24, 0, 1, 1, 32'hA0A0A0A0, 32'h20, 1));
    vecs.push_back(mkVec(0, 1, 32'hA2A2A2A2, 32'h28, 1, 1, 1, 32'hA0A0A0A0, 32'h20, 2));
    vecs.push_back(mkVec(0, 1, 32'hA3A3A3A3, 32'h2C, 1, 1, 1, 32'hA1A1A1A1, 32'h24, 2));
    vecs.push_back(mkVec(0, 1, 32'hA4A4A4A4, 32'h30, 1, 1, 1, 32'hA2A2A2A2, 32'h28, 2));
    vecs.push_back(mkVec(0, 1, 32'hA5A5A5A5, 32'h34, 1, 1, 1, 32'hA3A3A3A3, 32'h2C, 2));
    vecs.push_back(mkVec(0, 1, 32'hA6A6A6A6, 32'h38, 1, 1, 1, 32'hA4A4A4A4, 32'h30, 2));
    // Refill to full, then pop while an offer is pending.
    vecs.push_back(mkVec(0, 1, 32'hA7A7A7A7, 32'h3C, 0, 1, 1, 32'hA5A5A5A5, 32'h34, 2));
    vecs.push_back(mkVec(0, 1, 32'hA8A8A8A8, 32'h40, 0, 1, 1, 32'hA5A5A5A5, 32'h34, 3));
    vecs.push_back(mkVec(0, 1, 32'hA9A9A9A9, 32'h44, 1, 0, 1, 32'hA5A5A5A5, 32'h34, 4));
    vecs.push_back(mkVec(0, 1, 32'hA9A9A9A9, 32'h44, 0, 1, 1, 32'hA6A6A6A6, 32'h38, 3));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 0, 1, 32'hA6A6A6A6, 32'h38, 4));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 1, 1, 32'hA7A7A7A7, 32'h3C, 3));
    // Flush with push and pop requested at count 2.
    vecs.push_back(mkVec(1, 1, 32'hBBBBBBBB, 32'h200, 1, 1, 1, 32'hA8A8A8A8, 32'h40, 2));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 0, NOP,          32'h0,  0));
    vecs.push_back(mkVec(0, 1, 32'hDEADBEEF, 32'h100, 0, 1, 0, NOP,         32'h0,  0));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  1, 1, 1, 32'hDEADBEEF, 32'h100, 1));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 0, NOP,          32'h0,  0));
    // Push into empty: visible only one cycle later.
    vecs.push_back(mkVec(0, 1, 32'h00500093, 32'h104, 0, 1, 0, NOP,         32'h0,  0));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 1, 32'h00500093, 32'h104, 1));
    vecs.push_back(mkVec(0, 0, 32'h0,        32'h0,  0, 1, 1, 32'h00500093, 32'h104, 1));

    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].inInstr, vecs[i].inPc, vecs[i].outReady);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expInReady, vecs[i].expOutValid,
                  vecs[i].expInstr, vecs[i].expPc, vecs[i].expCount);
    end

    // Asynchronous reset in the middle of a stream at count 3.
    @(negedge clk);
    applyStimulus(0, 1, 32'hC1C1C1C1, 32'h108, 0);
    @(negedge clk);
    applyStimulus(0, 1, 32'hC2C2C2C2, 32'h10C, 0);
    @(negedge clk);
    applyStimulus(0, 1, 32'hC3C3C3C3, 32'h110, 0);
    #1;
    checkOutput("preReset", 1, 1, 32'h00500093, 32'h104, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 1, 0, NOP, 32'h0, 0);

    // First edge after release accepts a push.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'hE1E1E1E1, 32'h300, 0);
    #1;
    checkOutput("postResetPush", 1, 0, NOP, 32'h0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    #1;
    checkOutput("postResetHead", 1, 1, 32'hE1E1E1E1, 32'h300, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
